mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-stage bus sequencer. It sits directly upstream of the load-data extractor.
- Accepts one load or store per instruction from the memory-stage pipeline register and drives the data bus (dbus) request/response handshake.
- Builds the byte strobe and the lane-shifted write data.
- Captures the raw 64-bit response word, plus the low address bits and size, which the extractor consumes.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 64, width of the memory address.
- DATA_W, 64, dbus data width; 8 byte lanes (fixed; the strobe is DATA_W/8 bits).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  memory-stage instruction present.
- in_load  in  1  instruction is a load.
- in_store  in  1  instruction is a store; in_load and in_store are never both high.
- in_addr  in  ADDR_W  effective address.
- in_msize  in  msize_t  access size: MSIZE1, MSIZE2, MSIZE4 or MSIZE8.
- in_wdata  in  DATA_W  store data, right-aligned.
- in_ack  in  1  pipeline consumed the result (stage advances this cycle).
- dreq_valid  out  1  dbus request valid.
- dreq_addr  out  ADDR_W  request address, in_addr with the low 3 bits cleared.
- dreq_size  out  msize_t  request size.
- dreq_strobe  out  8  byte write enables; all 0 for a load.
- dreq_data  out  DATA_W  lane-shifted store data.
- dresp_addr_ok  in  1  address accepted.
- dresp_data_ok  in  1  data phase complete.
- dresp_data  in  DATA_W  raw read word.
- raw_rdata  out  DATA_W  captured word, fed to the extractor's raw-data input.
- lane_addr  out  3  captured in_addr[2:0], fed to the extractor's address input.
- lane_msize  out  msize_t  captured size.
- done  out  1  access complete; result valid.
- misalign  out  1  access aborted because the address is misaligned.
- stall  out  1  hold the upstream stages.

Behaviour:
- States: IDLE, REQ, DATA, HOLD. All transitions occur on the clk edge.
- Reset: state goes to IDLE. dreq_valid, done, misalign and stall go to 0. raw_rdata, dreq_strobe and dreq_data go to 0. lane_addr goes to 0.
- IDLE, with in_valid & (in_load | in_store):
  - Latch addr, size, strobe, shifted data and the load flag.
  - If misaligned, go to HOLD with misalign=1; no bus request is issued.
  - Otherwise go to REQ.
- IDLE with no memory op: stall=0, done=0; the block is transparent.
- REQ:
  - dreq_valid=1, with all request fields held stable until addr_ok.
  - addr_ok & data_ok in the same cycle: capture dresp_data (loads only), go to HOLD.
  - addr_ok only: go to DATA.
- DATA: dreq_valid=0. On data_ok, capture dresp_data (loads only) and go to HOLD.
- HOLD: done=1. raw_rdata and lane_* are held. On in_ack, go to IDLE and clear done and misalign.
- stall = in_valid & (in_load | in_store) & ~(state==HOLD). Minimum latency is 2 cycles (REQ, then HOLD) for a zero-wait bus.
- Misalignment:
  - MSIZE2 with addr[0] != 0.
  - MSIZE4 with addr[1:0] != 0.
  - MSIZE8 with addr[2:0] != 0.
  - MSIZE1 is never misaligned.
- Strobe by size:
  - MSIZE1: 8'h01 << addr[2:0].
  - MSIZE2: 8'h03 << {addr[2:1],1'b0}.
  - MSIZE4: 8'h0F << {addr[2],2'b00}.
  - MSIZE8: 8'hFF.
  - Loads: 8'h00.
- Store data: dreq_data = in_wdata << (8 * the strobe's lowest set lane). Bytes outside the strobe are don't-care but driven deterministically.
- A store in HOLD leaves raw_rdata unchanged from its previous value.
- in_valid dropping mid-transaction is ignored; the FSM completes the bus transaction it started.
- data_ok while in IDLE or HOLD is ignored and never captured.
- Reset mid-transaction: the FSM returns to IDLE next cycle and dreq_valid drops. Any outstanding bus response is dropped.

Decomposition:
- Shared package common: msize_t, and dbus_req_t/dbus_resp_t if bundled.
- New package constants: state enum mem_state_t and a STROBE_W=8 localparam.
- One natural sub-module: mem_strobe_gen (combinational). It maps addr[2:0], msize and is_store to strobe, shifted data and misalign.

Test Plan:
- Store MSIZE1, addr=0x...1003, wdata=0xAB, zero-wait bus -> dreq_strobe=8'h08, dreq_data[31:24]=0xAB, dreq_addr=0x...1000, done at cycle 2, stall high for cycles 0-1.
- Load MSIZE4, addr=0x...2004, addr_ok at cycle 1, data_ok at cycle 4 with dresp_data=0x11223344_55667788 -> raw_rdata=0x1122334455667788, lane_addr=3'b100, done at cycle 5, dreq_strobe=0.
- Load MSIZE8, addr=0x...3002 -> misalign=1, done=1 next cycle, dreq_valid never asserted.
- Stall during REQ with addr_ok low for 3 cycles -> dreq_addr, dreq_data and dreq_strobe stable for all 4 cycles.
- reset asserted in DATA -> next cycle state=IDLE, dreq_valid=0, done=0. A late data_ok is not captured.
- Back-to-back: load MSIZE2 addr 0x...06, then in_ack, then store MSIZE8 -> strobes 8'h00 then 8'hFF, with no bubble beyond one IDLE cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage bus sequencer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StHold
  } mem_state_t;

  localparam int unsigned STROBE_W = 8;

endpackage

// File: rtl/mem_access_if.sv
// Data bus request/response bundle between the sequencer (master) and memory (slave).
interface mem_access_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  import mem_access_pkg::*;

  logic                dreq_valid;
  logic [ADDR_W-1:0]   dreq_addr;
  msize_t              dreq_size;
  logic [STROBE_W-1:0] dreq_strobe;
  logic [DATA_W-1:0]   dreq_data;
  logic                dresp_addr_ok;
  logic                dresp_data_ok;
  logic [DATA_W-1:0]   dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );

endinterface

// File: rtl/mem_strobe_gen.sv
// Byte-strobe, lane-shifted store data and misalignment decode for one access.
module mem_strobe_gen
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]          addr_lo,
  input  msize_t              msize,
  input  logic                is_store,
  input  logic [DATA_W-1:0]   wdata,
  output logic [STROBE_W-1:0] strobe,
  output logic [DATA_W-1:0]   wdata_shifted,
  output logic                misalign
);

  logic [2:0]          lane;
  logic [STROBE_W-1:0] strobe_base;

  always_comb begin
    lane        = 3'd0;
    strobe_base = 8'h00;
    misalign    = 1'b0;
    unique case (msize)
      MSIZE1: begin
        lane        = addr_lo;
        strobe_base = 8'h01;
      end
      MSIZE2: begin
        lane        = {addr_lo[2:1], 1'b0};
        strobe_base = 8'h03;
        misalign    = addr_lo[0];
      end
      MSIZE4: begin
        lane        = {addr_lo[2], 2'b00};
        strobe_base = 8'h0F;
        misalign    = |addr_lo[1:0];
      end
      MSIZE8: begin
        lane        = 3'd0;
        strobe_base = 8'hFF;
        misalign    = |addr_lo;
      end
      default: ;
    endcase
    // Loads drive zero on both so the bus never sees stale write lanes.
    strobe        = is_store ? (strobe_base << lane) : '0;
    wdata_shifted = is_store ? (wdata << {lane, 3'b000}) : '0;
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage bus sequencer: issues one dbus access per load/store and holds the
// captured response for the load-data extractor until the pipeline acknowledges it.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  msize_t            in_msize,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_ack,
  mem_access_if.master      dbus,
  output logic [DATA_W-1:0] raw_rdata,
  output logic [2:0]        lane_addr,
  output msize_t            lane_msize,
  output logic              done,
  output logic              misalign,
  output logic              stall
);

  mem_state_t state_q, state_d;

  logic [ADDR_W-4:0]   addr_hi_q;
  msize_t              size_q;
  logic [STROBE_W-1:0] strobe_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                is_load_q;
  logic [2:0]          lane_addr_q;
  logic [DATA_W-1:0]   raw_rdata_q;
  logic                misalign_q;

  logic                mem_op;
  logic [STROBE_W-1:0] gen_strobe;
  logic [DATA_W-1:0]   gen_wdata;
  logic                gen_misalign;

  assign mem_op = in_valid & (in_load | in_store);

  mem_strobe_gen #(
    .DATA_W (DATA_W)
  ) u_strobe_gen (
    .addr_lo       (in_addr[2:0]),
    .msize         (in_msize),
    .is_store      (in_store),
    .wdata         (in_wdata),
    .strobe        (gen_strobe),
    .wdata_shifted (gen_wdata),
    .misalign      (gen_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_op) state_d = gen_misalign ? StHold : StReq;
      StReq: begin
        if (dbus.dresp_addr_ok) state_d = dbus.dresp_data_ok ? StHold : StData;
      end
      StData: if (dbus.dresp_data_ok) state_d = StHold;
      StHold: if (in_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dbus.dreq_valid = (state_q == StReq);
    done            = (state_q == StHold);
    stall           = mem_op & (state_q != StHold);
  end

  // Request fields only load in IDLE, so they stay stable through REQ/DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hi_q   <= '0;
      size_q      <= MSIZE1;
      strobe_q    <= '0;
      wdata_q     <= '0;
      is_load_q   <= 1'b0;
      lane_addr_q <= 3'd0;
      raw_rdata_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_op) begin
            addr_hi_q   <= in_addr[ADDR_W-1:3];
            size_q      <= in_msize;
            strobe_q    <= gen_strobe;
            wdata_q     <= gen_wdata;
            is_load_q   <= in_load;
            lane_addr_q <= in_addr[2:0];
            misalign_q  <= gen_misalign;
          end
        end
        StReq: begin
          if (dbus.dresp_addr_ok && dbus.dresp_data_ok && is_load_q) begin
            raw_rdata_q <= dbus.dresp_data;
          end
        end
        StData: begin
          if (dbus.dresp_data_ok && is_load_q) raw_rdata_q <= dbus.dresp_data;
        end
        StHold: begin
          if (in_ack) misalign_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dbus.dreq_addr   = {addr_hi_q, 3'b000};
  assign dbus.dreq_size   = size_q;
  assign dbus.dreq_strobe = strobe_q;
  assign dbus.dreq_data   = wdata_q;

  assign raw_rdata  = raw_rdata_q;
  assign lane_addr  = lane_addr_q;
  assign lane_msize = size_q;
  assign misalign   = misalign_q;

endmodule
